mult_share_arbiter: RTL

//  Shares one 8-cycle sequential shift-add multiplier between NREQ requesters.
//  - Arbitrates round-robin, then latches the winner's operands.
//  - Sequences the multiplier's start/ready protocol and routes the 16-bit product back to the winner.
//  - Sits between client blocks and a single multiplier instance; a watchdog guards against a hung multiplier.

---
 rtl/mult_share_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one sequential 8x8 shift-add multiplier between NREQ requesters.
//   A round-robin arbiter picks a requester and latches its operands. The
//   block then sequences the multiplier's start/ready handshake and returns
//   the 16-bit product to that requester. A watchdog turns a multiplier that
//   never raises mul_ready into an error response, so the arbiter cannot hang.
//
// Ports
//   clk, rst                     clock; synchronous active-high reset
//   req_valid/req_a/req_b        per-requester request and operands
//                                (requester i uses bits [8i+7:8i])
//   req_ready                    one-hot grant pulse; operands captured on this edge
//   resp_valid/resp_product/     one-hot result pulse, product, watchdog error flag
//   resp_err
//   busy                         high whenever the FSM is not in IDLE
//   mul_start/mul_a/mul_b        load pulse and held operands to the multiplier
//   mul_product/mul_ready        result and done flag from the multiplier
module mult_share_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_a,
    input  logic [NREQ*8-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   resp_valid,
    output logic [15:0]       resp_product,
    output logic              resp_err,
    output logic              busy,
    output logic              mul_start,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [15:0]       mul_product,
    input  logic              mul_ready
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    localparam logic [IW-1:0] LAST_REQ = IW'(NREQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] grant_q;
    logic [CW-1:0] wd_q;
    logic [15:0]   prod_q;
    logic          err_q;

    logic          pick_found;
    logic [IW-1:0] pick_idx;

    // Round-robin search: the first set request at or above rr_ptr, wrapping
    // from NREQ-1 to 0.
    always_comb begin
        int            idx;
        logic [IW-1:0] idx_w;
        // NOTE: every variable written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        idx_w      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            idx_w = IW'(idx);
            if (!pick_found && req_valid[idx_w]) begin
                pick_found = 1'b1;
                pick_idx   = idx_w;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and control outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        resp_valid = '0;
        mul_start  = 1'b0;
        busy       = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                // Gating with rst means a grant is never pulsed without its operands being captured.
                if (pick_found && !rst) begin
                    req_ready[pick_idx] = 1'b1;
                    state_d             = START;
                end
            end
            START: begin
                // mul_ready may still be high from the previous operation; ignore it.
                mul_start = 1'b1;
                state_d   = WAIT;
            end
            WAIT: begin
                if (mul_ready || (wd_q == WD_LAST)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp_valid[grant_q] = 1'b1;
                state_d             = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign resp_product = (state_q == RESP) ? prod_q : 16'h0000;
    assign resp_err     = (state_q == RESP) && err_q;

    // Datapath: operand latch, watchdog, result capture, round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
            grant_q  <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            wd_q     <= '0;
            prod_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        grant_q <= pick_idx;
                        mul_a   <= req_a[{pick_idx, 3'b000} +: 8];
                        mul_b   <= req_b[{pick_idx, 3'b000} +: 8];
                    end
                end
                START: begin
                    wd_q <= '0;
                end
                WAIT: begin
                    if (mul_ready) begin
                        prod_q <= mul_product;
                        err_q  <= 1'b0;
                    end else if (wd_q == WD_LAST) begin
                        prod_q <= 16'h0000;
                        err_q  <= 1'b1;
                    end else begin
                        wd_q <= wd_q + CW'(1);
                    end
                end
                RESP: begin
                    rr_ptr_q <= (grant_q == LAST_REQ) ? '0 : grant_q + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
